// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: two-flop synchronizer plus per-bit stability counter
// for bouncy slide switches.
//
// Parameters:
//   WIDTH           number of switch bits
//   CNT_W           width of each per-bit stability counter
//   DEBOUNCE_CYCLES stable clocks needed before a new level is accepted
//                   (1 .. 2**CNT_W-1)
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   sw_raw       in   raw switch levels, asynchronous to clk
//   sw_clean     out  debounced, synchronized levels (PIO in_port)
//   sw_changed   out  one-cycle pulse when any sw_clean bit updates
//   changed_mask out  bits of sw_clean that updated this cycle
//   edge_clr     in   per-bit clear of edge_flags      (SW_EDGE_LATCH_EN)
//   edge_flags   out  sticky rising-edge flags         (SW_EDGE_LATCH_EN)
//
// Optional feature macro: SW_EDGE_LATCH_EN adds the sticky rising-edge
// flag registers and their edge_clr/edge_flags ports.

module sw_debounce_sync #(
    parameter int WIDTH           = 8,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic             sw_changed,
`ifdef SW_EDGE_LATCH_EN
    output logic [WIDTH-1:0] changed_mask,
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] edge_flags
`else
    output logic [WIDTH-1:0] changed_mask
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0]            clean_q;
    logic [WIDTH-1:0]            clean_d;
    logic [WIDTH-1:0]            mask_q;
    logic [WIDTH-1:0]            mask_d;
    logic                        changed_q;
    logic                        changed_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

    // Any sample of sync2 equal to the accepted level restarts the count,
    // so only an unbroken run of DEBOUNCE_CYCLES differing samples lands.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        mask_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                clean_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                mask_d[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        changed_d = |mask_d;
    end

    // The synchronizer pair has nothing between the two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            clean_q   <= '0;
            mask_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            clean_q   <= clean_d;
            mask_q    <= mask_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sw_clean     = clean_q;
    assign sw_changed   = changed_q;
    assign changed_mask = mask_q;

`ifdef SW_EDGE_LATCH_EN
    logic [WIDTH-1:0] flags_q;
    logic [WIDTH-1:0] flags_d;

    // A new rising edge in the same cycle as a clear keeps the flag set.
    always_comb begin
        flags_d = (flags_q & ~edge_clr) | (mask_d & clean_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign edge_flags = flags_q;
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb_sw_debounce_sync: directed bench for sw_debounce_sync with
// DEBOUNCE_CYCLES=4; edge-flag steps build when SW_EDGE_LATCH_EN is set.

module tb_sw_debounce_sync;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic         sw_changed;
    logic [W-1:0] changed_mask;
`ifdef SW_EDGE_LATCH_EN
    logic [W-1:0] edge_clr;
    logic [W-1:0] edge_flags;
`endif

    int checks;
    int errors;
    int pulses;
    logic [W-1:0] last_mask;

    sw_debounce_sync #(
        .WIDTH(W),
        .CNT_W(16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .sw_changed(sw_changed),
`ifdef SW_EDGE_LATCH_EN
        .changed_mask(changed_mask),
        .edge_clr(edge_clr),
        .edge_flags(edge_flags)
`else
        .changed_mask(changed_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (sw_changed === 1'b1) begin
                pulses++;
                last_mask = changed_mask;
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pulses    = 0;
        last_mask = '0;
        reset_n   = 1'b0;
        sw_raw    = 8'h00;
`ifdef SW_EDGE_LATCH_EN
        edge_clr  = 8'h00;
`endif

        // Reset state, then 20 quiet clocks
        tick(2);
        chk("rst_clean", 32'(sw_clean), 32'h00);
        chk("rst_changed", 32'(sw_changed), 0);
        chk("rst_mask", 32'(changed_mask), 32'h00);
`ifdef SW_EDGE_LATCH_EN
        chk("rst_flags", 32'(edge_flags), 32'h00);
`endif
        reset_n = 1'b1;
        pulses  = 0;
        tick(20);
        chk("idle_clean", 32'(sw_clean), 32'h00);
        chk("idle_pulses", pulses, 0);

        // Single bit rise: accepted after edge E+5
        sw_raw = 8'h01;
        tick(4);
        chk("b0_e3_clean", 32'(sw_clean), 32'h00);
        tick(1);
        chk("b0_e4_clean", 32'(sw_clean), 32'h00);
        chk("b0_e4_pulses", pulses, 0);
        tick(1);
        chk("b0_e5_clean", 32'(sw_clean), 32'h01);
        chk("b0_e5_changed", 32'(sw_changed), 1);
        chk("b0_e5_mask", 32'(changed_mask), 32'h01);
        tick(1);
        chk("b0_e6_changed", 32'(sw_changed), 0);
        chk("b0_e6_mask", 32'(changed_mask), 32'h00);
        tick(3);
        chk("b0_pulses", pulses, 1);

        // Back to 0
        sw_raw = 8'h00;
        pulses = 0;
        tick(10);
        chk("b0_fall_clean", 32'(sw_clean), 32'h00);
        chk("b0_fall_pulses", pulses, 1);
        chk("b0_fall_mask", 32'(last_mask), 32'h01);

        // Bounce on bit 3: 3 high, 1 low, 3 high, then low
        pulses = 0;
        sw_raw = 8'h08;
        tick(3);
        sw_raw = 8'h00;
        tick(1);
        sw_raw = 8'h08;
        tick(3);
        sw_raw = 8'h00;
        tick(10);
        chk("bounce_clean", 32'(sw_clean), 32'h00);
        chk("bounce_pulses", pulses, 0);

        // Bit 3 held high long enough
        sw_raw = 8'h08;
        tick(5);
        chk("b3_e4_clean", 32'(sw_clean), 32'h00);
        tick(1);
        chk("b3_e5_clean", 32'(sw_clean), 32'h08);
        chk("b3_e5_mask", 32'(changed_mask), 32'h08);
        tick(2);
        chk("b3_pulses", pulses, 1);

        // Return to 0, then a multi-bit jump
        sw_raw = 8'h00;
        tick(10);
        chk("b3_fall_clean", 32'(sw_clean), 32'h00);
        pulses = 0;
        sw_raw = 8'hA5;
        tick(6);
        chk("a5_clean", 32'(sw_clean), 32'hA5);
        chk("a5_changed", 32'(sw_changed), 1);
        chk("a5_mask", 32'(changed_mask), 32'hA5);
        tick(6);
        chk("a5_pulses", pulses, 1);

        // Reset mid-count
        sw_raw = 8'hFF;
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("midrst_clean", 32'(sw_clean), 32'h00);
        chk("midrst_changed", 32'(sw_changed), 0);
        chk("midrst_mask", 32'(changed_mask), 32'h00);
        tick(1);
        reset_n = 1'b1;
        pulses  = 0;
        tick(5);
        chk("ff_e4_clean", 32'(sw_clean), 32'h00);
        tick(1);
        chk("ff_e5_clean", 32'(sw_clean), 32'hFF);
        chk("ff_e5_changed", 32'(sw_changed), 1);
        chk("ff_e5_mask", 32'(changed_mask), 32'hFF);
        chk("ff_pulses", pulses, 1);

`ifdef SW_EDGE_LATCH_EN
        chk("ff_flags", 32'(edge_flags), 32'hFF);
        edge_clr = 8'hFF;
        tick(1);
        edge_clr = 8'h00;
        chk("clr_all_flags", 32'(edge_flags), 32'h00);
        sw_raw = 8'h00;
        tick(8);
        chk("fall_flags", 32'(edge_flags), 32'h00);
        sw_raw = 8'h01;
        tick(6);
        chk("rise_flags", 32'(edge_flags), 32'h01);
        sw_raw = 8'h00;
        tick(8);
        chk("sticky_clean", 32'(sw_clean), 32'h00);
        chk("sticky_flags", 32'(edge_flags), 32'h01);
        edge_clr = 8'h01;
        tick(1);
        edge_clr = 8'h00;
        chk("clr_flags", 32'(edge_flags), 32'h00);
        tick(2);
        edge_clr = 8'h01;
        sw_raw   = 8'h01;
        tick(5);
        chk("setwin_e4_flags", 32'(edge_flags), 32'h00);
        tick(1);
        chk("setwin_e5_clean", 32'(sw_clean), 32'h01);
        chk("setwin_e5_flags", 32'(edge_flags), 32'h01);
        tick(1);
        chk("setwin_e6_flags", 32'(edge_flags), 32'h00);
        edge_clr = 8'h00;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
